dm_access_ctrl: RTL and testbench

//  Sequences and shares the single-port word-addressed data memory between the

---
 rtl/dm_ctrl_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 39 +++
 rtl/dm_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared types, sizes and the byte-enable merge helper for the data-memory
// access controller.
package dm_ctrl_pkg;

  localparam int DEPTH  = 3072;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Replace the bytes selected by be with new data, keep the rest of the old word.
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_word,
                                                 input logic [DATA_W-1:0] new_word,
                                                 input logic [3:0]        be);
    logic [DATA_W-1:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational; the winner is
// remembered so the other requester wins the next conflict.
module rr_arb2
  import dm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_grant;

  // One-hot grant: lone requester wins, a conflict goes to the one not served last.
  always_comb begin
    // NOTE: default every output first so no path through the block leaves it unassigned (latch).
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the most recent winner; reset favours the CPU on the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      last_grant <= REQ_DMA;
    end else if (gnt != 2'b00) begin
      last_grant <= gnt[1] ? REQ_DMA : REQ_CPU;
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Shares the single-port data memory between the CPU M stage and the DMA/debug
// port, and runs a bulk-clear engine that zeroes one word per cycle.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic              dma_we,
  input  logic [ADDR_W+1:0] dma_addr,
  input  logic [3:0]        dma_be,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              acc_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_word;
  logic [3:0]        sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              unused_addr_lsbs;

  // Byte offsets are meaningless for a word-wide memory.
  assign unused_addr_lsbs = ^{cpu_addr[1:0], dma_addr[1:0]};

  // Requests are served only in IDLE; a clear start wins over any pending request,
  // and nothing is accepted while reset is held.
  assign arb_en = (state == ST_IDLE) && !clr_start && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({dma_valid, cpu_valid}),
    .gnt   (gnt)
  );

  assign cpu_ready = gnt[REQ_CPU];
  assign dma_ready = gnt[REQ_DMA];
  assign acc       = |gnt;

  // Steer the winning port's request onto a single internal request.
  always_comb begin
    if (gnt[REQ_DMA]) begin
      sel_we    = dma_we;
      sel_word  = dma_addr[ADDR_W+1:2];
      sel_be    = dma_be;
      sel_wdata = dma_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_word  = cpu_addr[ADDR_W+1:2];
      sel_be    = cpu_be;
      sel_wdata = cpu_wdata;
    end
    in_range = sel_word < ADDR_W'(DEPTH);
  end

  // Memory control: clear sweep, merged store, or quiet bus when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_ptr;
    end else if (acc) begin
      mem_addr = sel_word;
      if (sel_we && in_range && (sel_be != 4'b0000)) begin
        mem_we    = 1'b1;
        mem_wdata = be_merge(mem_rdata, sel_wdata, sel_be);
      end
    end
  end

  // IDLE/CLEAR sequencer with the clear pointer and registered busy/done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      clr_ptr  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-port load return: capture read data, pulse rvalid, flag out-of-range accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      acc_err    <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      acc_err    <= acc && !in_range;
      if (gnt[REQ_CPU] && !cpu_we) begin
        cpu_rvalid <= 1'b1;
        cpu_rdata  <= in_range ? mem_rdata : '0;
      end
      if (gnt[REQ_DMA] && !dma_we) begin
        dma_rvalid <= 1'b1;
        dma_rdata  <= in_range ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomised scoreboard bench for dm_access_ctrl with a word-array reference
// memory and a behavioural memory attached to the DUT's memory port.
module tb_dm_access_ctrl;
  import dm_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
  logic [13:0]       cpu_addr;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata, cpu_rdata;
  logic              dma_valid, dma_ready, dma_we, dma_rvalid;
  logic [13:0]       dma_addr;
  logic [3:0]        dma_be;
  logic [31:0]       dma_wdata, dma_rdata;
  logic              clr_start, clr_busy, clr_done, acc_err;
  logic              mem_we;
  logic [11:0]       mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_be(dma_be), .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .acc_err(acc_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical memory behind the controller: combinational read, clocked write.
  logic [31:0] mem [DEPTH];
  assign mem_rdata = (mem_addr < 12'(DEPTH)) ? mem[mem_addr] : 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state.
  typedef struct {
    bit          v;
    bit          we;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic [31:0] ref_mem [DEPTH];
  req_t        pend [2];
  int          last_w;
  exp_t        rq_cpu [$];
  exp_t        rq_dma [$];
  int          err_q  [$];
  logic [31:0] last_dut_wdata;
  logic        obs_done;

  // Monitor: every load return and error pulse must match a queued expectation.
  logic [31:0] held_cpu = '0;
  logic [31:0] held_dma = '0;
  exp_t        e_mon;
  int          err_cyc;
  always @(negedge clk) begin
    if (reset) begin
      held_cpu = '0;
      held_dma = '0;
    end else begin
      if (cpu_rvalid) begin
        if (rq_cpu.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'h0);
        else begin
          e_mon = rq_cpu.pop_front();
          check("cpu_rdata", cpu_rdata, e_mon.data);
          check("cpu_rvalid_cycle", cyc, e_mon.cyc);
          held_cpu = e_mon.data;
        end
      end else check("cpu_rdata_hold", cpu_rdata, held_cpu);
      if (dma_rvalid) begin
        if (rq_dma.size() == 0) check("dma_rvalid_unexpected", 32'(dma_rvalid), 32'h0);
        else begin
          e_mon = rq_dma.pop_front();
          check("dma_rdata", dma_rdata, e_mon.data);
          check("dma_rvalid_cycle", cyc, e_mon.cyc);
          held_dma = e_mon.data;
        end
      end else check("dma_rdata_hold", dma_rdata, held_dma);
      if (acc_err) begin
        if (err_q.size() == 0) check("acc_err_unexpected", 32'(acc_err), 32'h0);
        else begin
          err_cyc = err_q.pop_front();
          check("acc_err_cycle", cyc, err_cyc);
        end
      end
    end
  end

  function automatic req_t mk_req(input bit we, input logic [13:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata);
    req_t r;
    r.v = 1'b1; r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
    return r;
  endfunction

  // Random request: mostly words 0..15, about one in eight beyond the memory.
  function automatic req_t rand_req();
    int word;
    if ($urandom_range(0, 7) == 0) word = $urandom_range(DEPTH, 4095);
    else                           word = $urandom_range(0, 15);
    return mk_req(1'($urandom_range(0, 1)), {12'(word), 2'($urandom_range(0, 3))},
                  4'($urandom), $urandom);
  endfunction

  task automatic drive_inputs();
    cpu_valid = pend[0].v; cpu_we = pend[0].we; cpu_addr = pend[0].addr;
    cpu_be    = pend[0].be; cpu_wdata = pend[0].wdata;
    dma_valid = pend[1].v; dma_we = pend[1].we; dma_addr = pend[1].addr;
    dma_be    = pend[1].be; dma_wdata = pend[1].wdata;
  endtask

  // Apply an accepted request to the reference memory and queue its responses.
  task automatic model_access(input int p);
    req_t        r;
    int          word;
    bit          inr;
    logic [31:0] nw;
    exp_t        e;
    r    = pend[p];
    word = int'(r.addr[13:2]);
    inr  = word < DEPTH;
    check("mem_addr", mem_addr, 32'(word));
    if (r.we) begin
      check("store_mem_we", 32'(mem_we), 32'(inr && r.be != 4'h0));
      if (inr && r.be != 4'h0) begin
        nw = ref_mem[word];
        for (int b = 0; b < 4; b++) if (r.be[b]) nw[8*b +: 8] = r.wdata[8*b +: 8];
        check("mem_wdata", mem_wdata, nw);
        last_dut_wdata = mem_wdata;
        ref_mem[word]  = nw;
      end
    end else begin
      check("load_mem_we", 32'(mem_we), 32'h0);
      e.data = inr ? ref_mem[word] : 32'h0;
      e.cyc  = cyc + 1;
      if (p == 0) rq_cpu.push_back(e);
      else        rq_dma.push_back(e);
    end
    if (!inr) err_q.push_back(cyc + 1);
  endtask

  // One cycle of arbitration, entered just after a falling edge.
  task automatic cycle_body(output int dut_win);
    int win;
    drive_inputs();
    #1;
    obs_done = clr_done;
    if (pend[0].v && pend[1].v) win = (last_w == 1) ? 0 : 1;
    else if (pend[0].v)         win = 0;
    else if (pend[1].v)         win = 1;
    else                        win = -1;
    dut_win = cpu_ready ? 0 : (dma_ready ? 1 : -1);
    check("cpu_ready", 32'(cpu_ready), 32'(win == 0));
    check("dma_ready", 32'(dma_ready), 32'(win == 1));
    if (win >= 0) begin
      model_access(win);
      last_w      = win;
      pend[win].v = 1'b0;
    end else begin
      check("idle_mem_we", 32'(mem_we), 32'h0);
      check("idle_mem_addr", mem_addr, 32'h0);
    end
  endtask

  task automatic run_cycle(output int dut_win);
    @(negedge clk);
    cycle_body(dut_win);
    @(posedge clk);
  endtask

  // Serve everything pending, then one idle cycle so the valids go low.
  task automatic drain();
    int w;
    for (int g = 0; g < 8 && (pend[0].v || pend[1].v); g++) run_cycle(w);
    run_cycle(w);
  endtask

  int busy_cycles, bad, w, win_hist [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    pend[0] = '{default: '0};
    pend[1] = '{default: '0};
    reset = 1'b1; clr_start = 1'b0;
    drive_inputs();
    cpu_valid = 1'b1; dma_valid = 1'b1;
    #12;
    check("rst_cpu_ready", 32'(cpu_ready), 0);
    check("rst_dma_ready", 32'(dma_ready), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_clr_done", 32'(clr_done), 0);
    check("rst_acc_err", 32'(acc_err), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    cpu_valid = 1'b0; dma_valid = 1'b0;
    @(negedge clk); reset = 1'b0; last_w = 1;

    // Fill the working window through the DMA port.
    for (int i = 0; i < 16; i++) begin
      pend[1] = mk_req(1'b1, 14'(i << 2), 4'hF, $urandom);
      run_cycle(w);
    end
    drain();

    // Fresh reset, then both ports load for three cycles.
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; last_w = 1;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v) pend[p] = mk_req(1'b0, 14'((k + p) << 2), 4'h0, 32'h0);
      run_cycle(win_hist[k]);
    end
    check("conflict_grant0", win_hist[0], 0);
    check("conflict_grant1", win_hist[1], 1);
    check("conflict_grant2", win_hist[2], 0);
    drain();

    // Store then load at byte 0x10 on the CPU port.
    pend[0] = mk_req(1'b1, 14'h10, 4'hF, 32'hDEADBEEF); run_cycle(w);
    check("t1_store_wdata", last_dut_wdata, 32'hDEADBEEF);
    pend[0] = mk_req(1'b0, 14'h10, 4'h0, 32'h0); run_cycle(w);
    drain();

    // Byte merge from the DMA port.
    pend[0] = mk_req(1'b1, 14'h10, 4'hF, 32'h11223344); run_cycle(w);
    pend[1] = mk_req(1'b1, 14'h10, 4'b0101, 32'hAABBCCDD); run_cycle(w);
    check("t2_merge", last_dut_wdata, 32'h11BB33DD);
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 3) != 0) pend[p] = rand_req();
      run_cycle(w);
    end
    drain();

    // Out-of-range store.
    pend[0] = mk_req(1'b1, 14'h3000, 4'hF, 32'h12345678); run_cycle(w);
    drain();

    // Bulk clear with requests held pending throughout.
    pend[0] = mk_req(1'b1, 14'h2FFC, 4'hF, 32'h5); run_cycle(w);
    drain();
    @(negedge clk);
    pend[0] = mk_req(1'b0, 14'h2FFC, 4'h0, 32'h0);
    pend[1] = mk_req(1'b0, 14'h0010, 4'h0, 32'h0);
    clr_start = 1'b1;
    drive_inputs();
    #1;
    check("clr_start_cpu_ready", 32'(cpu_ready), 0);
    check("clr_start_dma_ready", 32'(dma_ready), 0);
    @(posedge clk);
    @(negedge clk); clr_start = 1'b0;
    busy_cycles = 0; bad = 0;
    for (int g = 0; g < 4000; g++) begin
      #1;
      if (!clr_busy) break;
      if (!(mem_we === 1'b1 && mem_addr === 12'(busy_cycles) && mem_wdata === 32'h0 &&
            !cpu_ready && !dma_ready && !clr_done)) bad++;
      busy_cycles++;
      @(negedge clk);
    end
    check("clr_busy_cycles", busy_cycles, 3072);
    check("clr_bad_cycles", bad, 0);
    check("clr_done_pulse", 32'(clr_done), 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cycle_body(w);
    @(posedge clk);
    run_cycle(w);
    check("clr_done_once", 32'(obs_done), 0);
    drain();

    // Async reset in the middle of a clear.
    for (int c = 0; c < 30; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 1) != 0) pend[p] = rand_req();
      run_cycle(w);
    end
    drain();
    @(negedge clk); clr_start = 1'b1; drive_inputs();
    @(posedge clk);
    @(negedge clk); clr_start = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    check("t6_busy_before", 32'(clr_busy), 1);
    reset = 1'b1;
    #1;
    check("t6_busy_async_drop", 32'(clr_busy), 0);
    check("t6_mem_we_drop", 32'(mem_we), 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_done_in_reset", 32'(clr_done), 0);
    @(negedge clk); reset = 1'b0; last_w = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int c = 0; c < 3; c++) begin
      run_cycle(w);
      check("t6_no_done_after", 32'(obs_done), 0);
    end
    pend[0] = mk_req(1'b0, 14'h0004, 4'h0, 32'h0);
    pend[1] = mk_req(1'b0, 14'h0008, 4'h0, 32'h0);
    run_cycle(w);
    check("t6_first_grant_cpu", w, 0);
    drain();
    run_cycle(w);

    check("cpu_queue_empty", rq_cpu.size(), 0);
    check("dma_queue_empty", rq_dma.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
